// File: rtl/seg_pkg.sv
// seg_pkg: shared glyph table, special segment patterns and leading-zero helper
// Segment vectors are active-low, ordered g..a (bit 6 = g, bit 0 = a).
package seg_pkg;
    localparam logic [6:0] SEG_E   = 7'b0000110;
    localparam logic [6:0] SEG_R   = 7'b0101111;
    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [6:0] GLYPHS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    function automatic logic [6:0] hex7(input logic [3:0] n);
        return GLYPHS[n];
    endfunction
    // Bit k set when nibbles k..n-1 are all zero; digit 0 is never blanked.
    function automatic logic [15:0] lz_vec(input logic [63:0] v, input int n);
        logic z;
        z = 1'b1;
        lz_vec = '0;
        for (int k = 15; k >= 0; k--) begin
            if (k < n) z = z & (v[4*k +: 4] == 4'h0);
            lz_vec[k] = z && (k < n);
        end
        lz_vec[0] = 1'b0;
    endfunction
endpackage

// File: rtl/seg_tick_gen.sv
// seg_tick_gen: refresh prescaler, one-cycle tick every DIV clocks
// Ports: clk system clock; rst async active-high reset; tick high on count DIV-1.
module seg_tick_gen #(
    parameter int DIV = 10000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = $clog2(DIV);
    logic [CW-1:0] r_cnt;
    assign tick = r_cnt == CW'(DIV - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) r_cnt <= '0;
        else     r_cnt <= tick ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed common-anode 7-segment scanner with blanking, blink and error modes
// Ports: clk, rst (async active-high); value/dp/mask/blink/lz_blank/error display inputs,
// snapshotted once per frame; anodes (active-low digit enables), cathodes (active-low, bit7 = dp).
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int DIV          = 10000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     mask,
    input  logic [DIGITS-1:0]     blink,
    input  logic                  lz_blank,
    input  logic                  error,
    output logic [DIGITS-1:0]     anodes,
    output logic [7:0]            cathodes
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic                w_tick, w_wrap, w_dark;
    logic [4:0]          w_idx;
    logic [3:0]          w_nib;
    logic [6:0]          w_seg;
    logic [15:0]         w_lz;
    logic [DIGITS-1:0]   w_an;
    logic [7:0]          w_cat;
    logic [IW-1:0]       r_idx;
    logic [FW-1:0]       r_frame;
    logic                r_dead, r_phase, r_lz, r_err;
    logic [DIGITS-1:0]   r_anodes, r_dp, r_mask, r_blink;
    logic [7:0]          r_cathodes;
    logic [4*DIGITS-1:0] r_value;
    seg_tick_gen #(.DIV(DIV)) u_tick (.clk(clk), .rst(rst), .tick(w_tick));
    assign anodes   = r_anodes;
    assign cathodes = r_cathodes;
    // Pattern for the current digit, built only from the frame snapshot.
    always_comb begin
        w_wrap = r_idx == IW'(DIGITS - 1);
        w_idx  = 5'(r_idx);
        w_nib  = r_value[{r_idx, 2'b00} +: 4];
        w_lz   = lz_vec(64'(r_value), DIGITS);
        w_dark = r_err ? (w_idx > 5'd2)
                       : (r_mask[r_idx] | (r_blink[r_idx] & r_phase) | (r_lz & w_lz[w_idx[3:0]]));
        w_seg  = r_err ? ((w_idx == 5'd2) ? SEG_E : (w_idx < 5'd2) ? SEG_R : SEG_OFF) : hex7(w_nib);
        w_cat  = w_dark ? 8'hFF : {r_err | ~r_dp[r_idx], w_seg};
        w_an   = w_dark ? '1 : ~(DIGITS'(1) << r_idx);
    end
    // Tick edge blanks and advances; the following edge (dead) lights the new digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx      <= '0;
            r_frame    <= '0;
            r_phase    <= 1'b0;
            r_dead     <= 1'b1;
            r_anodes   <= '1;
            r_cathodes <= 8'hFF;
            r_value    <= '0;
            r_dp       <= '0;
            r_mask     <= '0;
            r_blink    <= '0;
            r_lz       <= 1'b0;
            r_err      <= 1'b0;
        end else if (w_tick) begin
            r_idx      <= w_wrap ? '0 : r_idx + 1'b1;
            r_anodes   <= '1;
            r_cathodes <= 8'hFF;
            r_dead     <= 1'b1;
            if (w_wrap) begin
                r_value <= value;
                r_dp    <= dp;
                r_mask  <= mask;
                r_blink <= blink;
                r_lz    <= lz_blank;
                r_err   <= error;
                r_frame <= (r_frame == FW'(BLINK_FRAMES - 1)) ? '0 : r_frame + 1'b1;
                r_phase <= r_phase ^ (r_frame == FW'(BLINK_FRAMES - 1));
            end
        end else if (r_dead) begin
            r_anodes   <= w_an;
            r_cathodes <= w_cat;
            r_dead     <= 1'b0;
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed self-checking bench for seg_scan_driver (DIGITS=4, DIV=4, BLINK_FRAMES=2)
module tb_seg_scan_driver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0, mask = '0, blink = '0;
    logic        lz_blank = 1'b0, error = 1'b0;
    logic [3:0]  anodes;
    logic [7:0]  cathodes;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seg_scan_driver #(.DIGITS(4), .DIV(4), .BLINK_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .value(value), .dp(dp), .mask(mask), .blink(blink),
        .lz_blank(lz_blank), .error(error), .anodes(anodes), .cathodes(cathodes)
    );

    task automatic set_in(input logic [15:0] v, input logic [3:0] d, input logic [3:0] m,
                          input logic [3:0] b, input logic l, input logic e);
        value = v; dp = d; mask = m; blink = b; lz_blank = l; error = e;
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        set_in(16'h12A0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({anodes, cathodes} !== {4'hF, 8'hFF}) begin
            fails++;
            $display("FAIL reset_hold: anodes=%b cathodes=%h, expected 1111 ff", anodes, cathodes);
        end
        rst = 1'b0;
        #1;
        tests++;
        if ({anodes, cathodes} !== {4'hF, 8'hFF}) begin
            fails++;
            $display("FAIL reset_first_cycle: anodes=%b cathodes=%h, expected 1111 ff", anodes, cathodes);
        end
    endtask

    task automatic test_scan;
        logic [7:0] tab [4] = '{8'hC0, 8'h88, 8'hA4, 8'hF9};
        logic [3:0] ea;
        logic [7:0] ec;
        int s, d, fr;
        set_in(16'h12A0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        apply_reset;
        for (int e = 1; e <= 48; e++) begin
            @(negedge clk);
            s = (e - 1) / 4; d = s % 4; fr = s / 4;
            if ((e - 1) % 4 == 3) begin
                ea = 4'hF; ec = 8'hFF;
            end else begin
                ea = ~(4'b0001 << d); ec = (fr == 0) ? 8'hC0 : tab[d];
            end
            tests++;
            if ({anodes, cathodes} !== {ea, ec}) begin
                fails++;
                $display("FAIL scan e=%0d: anodes=%b cathodes=%h, expected %b %h", e, anodes, cathodes, ea, ec);
            end
        end
    endtask

    task automatic test_lz_dp;
        logic [3:0] ea;
        logic [7:0] ec;
        int d;
        set_in(16'h0050, 4'b0010, 4'h0, 4'h0, 1'b1, 1'b0);
        apply_reset;
        repeat (16) @(negedge clk);
        for (int e = 17; e <= 32; e++) begin
            @(negedge clk);
            d = ((e - 1) / 4) % 4;
            if ((e - 1) % 4 == 3 || d >= 2) begin
                tests++;
                if (anodes !== 4'hF) begin
                    fails++;
                    $display("FAIL lz_dark e=%0d: anodes=%b, expected 1111", e, anodes);
                end
            end else begin
                ea = (d == 0) ? 4'b1110 : 4'b1101;
                ec = (d == 0) ? 8'hC0 : 8'h12;
                tests++;
                if ({anodes, cathodes} !== {ea, ec}) begin
                    fails++;
                    $display("FAIL lz_lit e=%0d: anodes=%b cathodes=%h, expected %b %h", e, anodes, cathodes, ea, ec);
                end
            end
        end
    endtask

    task automatic test_snapshot;
        logic [3:0] ea;
        logic [7:0] ec;
        int s, d, fr;
        set_in(16'h1111, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        apply_reset;
        for (int e = 1; e <= 48; e++) begin
            @(negedge clk);
            s = (e - 1) / 4; d = s % 4; fr = s / 4;
            if ((e - 1) % 4 == 3) begin
                ea = 4'hF; ec = 8'hFF;
            end else begin
                ea = ~(4'b0001 << d);
                ec = (fr == 0) ? 8'hC0 : (fr == 1) ? 8'hF9 : 8'hA4;
            end
            tests++;
            if ({anodes, cathodes} !== {ea, ec}) begin
                fails++;
                $display("FAIL snapshot e=%0d: anodes=%b cathodes=%h, expected %b %h", e, anodes, cathodes, ea, ec);
            end
            if (e == 22) value = 16'h2222;
        end
    endtask

    task automatic test_error;
        logic [3:0] ea;
        logic [7:0] ec;
        int d;
        set_in(16'hFFFF, 4'hF, 4'hF, 4'h0, 1'b0, 1'b1);
        apply_reset;
        repeat (16) @(negedge clk);
        for (int e = 17; e <= 32; e++) begin
            @(negedge clk);
            d = ((e - 1) / 4) % 4;
            if ((e - 1) % 4 == 3 || d == 3) begin
                tests++;
                if (anodes !== 4'hF) begin
                    fails++;
                    $display("FAIL error_dark e=%0d: anodes=%b, expected 1111", e, anodes);
                end
            end else begin
                ea = ~(4'b0001 << d);
                ec = (d == 2) ? 8'h86 : 8'hAF;
                tests++;
                if ({anodes, cathodes} !== {ea, ec}) begin
                    fails++;
                    $display("FAIL error_lit e=%0d: anodes=%b cathodes=%h, expected %b %h", e, anodes, cathodes, ea, ec);
                end
            end
        end
    endtask

    task automatic test_blink;
        logic [7:0] tab [4] = '{8'hF9, 8'hA4, 8'hB0, 8'h99};
        logic [3:0] ea;
        logic [7:0] ec;
        int s, d, fr;
        set_in(16'h4321, 4'h0, 4'h0, 4'b0001, 1'b0, 1'b0);
        apply_reset;
        for (int e = 1; e <= 96; e++) begin
            @(negedge clk);
            s = (e - 1) / 4; d = s % 4; fr = s / 4;
            if ((e - 1) % 4 == 3 || (d == 0 && (fr == 2 || fr == 3))) begin
                tests++;
                if (anodes !== 4'hF) begin
                    fails++;
                    $display("FAIL blink_dark e=%0d: anodes=%b, expected 1111", e, anodes);
                end
            end else begin
                ea = ~(4'b0001 << d);
                ec = (fr == 0) ? 8'hC0 : tab[d];
                tests++;
                if ({anodes, cathodes} !== {ea, ec}) begin
                    fails++;
                    $display("FAIL blink_lit e=%0d: anodes=%b cathodes=%h, expected %b %h", e, anodes, cathodes, ea, ec);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        set_in(16'h12A0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        apply_reset;
        repeat (25) @(negedge clk);
        tests++;
        if ({anodes, cathodes} !== {4'b1011, 8'hA4}) begin
            fails++;
            $display("FAIL mid_before: anodes=%b cathodes=%h, expected 1011 a4", anodes, cathodes);
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({anodes, cathodes} !== {4'hF, 8'hFF}) begin
            fails++;
            $display("FAIL mid_async: anodes=%b cathodes=%h, expected 1111 ff", anodes, cathodes);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if ({anodes, cathodes} !== {4'hF, 8'hFF}) begin
            fails++;
            $display("FAIL mid_dead: anodes=%b cathodes=%h, expected 1111 ff", anodes, cathodes);
        end
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk);
            tests++;
            if (e == 4 ? ({anodes, cathodes} !== {4'hF, 8'hFF})
                       : e == 5 ? ({anodes, cathodes} !== {4'b1101, 8'hC0})
                                : ({anodes, cathodes} !== {4'b1110, 8'hC0})) begin
                fails++;
                $display("FAIL mid_restart e=%0d: anodes=%b cathodes=%h", e, anodes, cathodes);
            end
        end
    endtask

    initial begin
        test_reset;
        test_scan;
        test_lz_dp;
        test_snapshot;
        test_error;
        test_blink;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
